// File: rtl/instr_seq_if.sv
// Byte-wide memory read port between instr_seq (master) and instruction memory (slave).
// A request is held with a stable address until the cycle the slave acks it.
interface instr_seq_if;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [7:0]  i_mem_data;

    modport master (output o_mem_req, o_mem_addr, input  i_mem_ack, i_mem_data);
    modport slave  (input  o_mem_req, o_mem_addr, output i_mem_ack, i_mem_data);
endinterface

// File: rtl/instr_seq.sv
// Instruction fetch/decode sequencer: fetches a 16-bit word plus an optional 1/2/4-byte
// little-endian immediate over a byte port, decodes it and strobes write-back once.
module instr_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    instr_seq_if.master mem,
    output logic [3:0]  o_alu_action,
    output logic [1:0]  o_fmt,
    output logic [3:0]  o_rd_sel,
    output logic [3:0]  o_rs_sel,
    output logic        o_use_imm,
    output logic [31:0] o_imm,
    output logic        o_wb_en,
    output logic [31:0] o_pc,
    output logic        o_fault
);
    localparam logic [1:0] FMT_1B = 2'd1;
    localparam logic [1:0] FMT_2B = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F0    = 3'd1,
        S_F1    = 3'd2,
        S_IMM   = 3'd3,
        S_EXEC  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] instr_lo;
    logic [1:0] imm_cnt;
    logic [1:0] imm_last;
    logic       fetching;
    logic       take;

    assign fetching = (state_q == S_F0) || (state_q == S_F1) || (state_q == S_IMM);
    // An ack only counts while a request is actually outstanding.
    assign take     = fetching && mem.i_mem_ack;
    assign imm_last = (o_fmt == FMT_1B) ? 2'd0 : (o_fmt == FMT_2B) ? 2'd1 : 2'd3;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_run) state_d = S_F0;
            S_F0:    if (take) state_d = S_F1;
            S_F1:    if (take) begin
                         if (mem.i_mem_data[7])      state_d = S_FAULT;
                         else if (mem.i_mem_data[6]) state_d = S_IMM;
                         else                        state_d = S_EXEC;
                     end
            S_IMM:   if (take && imm_cnt == imm_last) state_d = S_EXEC;
            S_EXEC:  state_d = i_run ? S_F0 : S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem.o_mem_req  = fetching;
        mem.o_mem_addr = o_pc;
        o_wb_en        = (state_q == S_EXEC);
        o_fault        = (state_q == S_FAULT);
    end

    // Fetch datapath: PC advances on the same edge that accepts a byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pc         <= RESET_PC;
            instr_lo     <= 8'h00;
            imm_cnt      <= 2'd0;
            o_alu_action <= 4'h0;
            o_fmt        <= 2'd0;
            o_rd_sel     <= 4'h0;
            o_rs_sel     <= 4'h0;
            o_use_imm    <= 1'b0;
            o_imm        <= 32'h0;
        end else if (take) begin
            o_pc <= o_pc + 32'd1;
            case (state_q)
                S_F0: instr_lo <= mem.i_mem_data;
                S_F1: begin
                    o_alu_action <= instr_lo[3:0];
                    o_fmt        <= instr_lo[5:4];
                    o_rd_sel     <= {mem.i_mem_data[1:0], instr_lo[7:6]};
                    o_rs_sel     <= mem.i_mem_data[5:2];
                    o_use_imm    <= mem.i_mem_data[6];
                    o_imm        <= 32'h0;
                    imm_cnt      <= 2'd0;
                end
                S_IMM: begin
                    o_imm[{imm_cnt, 3'b000} +: 8] <= mem.i_mem_data;
                    imm_cnt                       <= imm_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: byte memory model with per-address stall injection,
// plus a second instance with RESET_PC = FFFF_FFFF for the PC wrap case.
module tb_instr_seq;
    localparam logic [1:0] FMT_1B = 2'd1;
    localparam logic [1:0] FMT_2B = 2'd2;
    localparam logic [1:0] FMT_4B = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    always #5 clk = ~clk;

    instr_seq_if mif();
    instr_seq_if mif2();

    logic [3:0]  alu, rd, rs, alu2, rd2, rs2;
    logic [1:0]  fmt, fmt2;
    logic        use_imm, wb_en, fault, use_imm2, wb_en2, fault2;
    logic [31:0] imm, pc, imm2, pc2;

    instr_seq dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .mem(mif),
        .o_alu_action(alu), .o_fmt(fmt), .o_rd_sel(rd), .o_rs_sel(rs),
        .o_use_imm(use_imm), .o_imm(imm), .o_wb_en(wb_en), .o_pc(pc), .o_fault(fault)
    );

    instr_seq #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .mem(mif2),
        .o_alu_action(alu2), .o_fmt(fmt2), .o_rd_sel(rd2), .o_rs_sel(rs2),
        .o_use_imm(use_imm2), .o_imm(imm2), .o_wb_en(wb_en2), .o_pc(pc2), .o_fault(fault2)
    );

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] stall_addr = 32'h0;
    int          stall_cnt  = 0;
    logic        force_ack  = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    // Memory responds between edges; outputs are sampled #1 after the rising edge.
    always @(negedge clk) begin
        if (force_ack) begin
            mif.i_mem_ack  = 1'b1;
            mif.i_mem_data = 8'hEE;
        end else if (mif.o_mem_req) begin
            if (mif.o_mem_addr == stall_addr && stall_cnt > 0) begin
                mif.i_mem_ack = 1'b0;
                stall_cnt     = stall_cnt - 1;
            end else begin
                mif.i_mem_ack  = 1'b1;
                mif.i_mem_data = mem.exists(mif.o_mem_addr) ? mem[mif.o_mem_addr] : 8'h00;
            end
        end else begin
            mif.i_mem_ack = 1'b0;
        end
        mif2.i_mem_ack  = mif2.o_mem_req;
        mif2.i_mem_data = 8'h00;
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        force_ack = 1'b0;
        stall_cnt = 0;
        mem.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raises run and counts cycles until write-back or fault; leaves run high.
    task automatic run_instr(input int max, output int cycles, output int reqs);
        bit done = 0;
        run = 1'b1;
        cycles = 0;
        reqs = 0;
        while (!done && cycles < max) begin
            @(posedge clk); #1;
            cycles++;
            if (mif.o_mem_req) reqs++;
            if (wb_en || fault) done = 1;
        end
    endtask

    task automatic test_reset();
        mif.i_mem_ack = 1'b0; mif.i_mem_data = 8'h00;
        do_reset();
        n_chk++; if (mif.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mif.o_mem_req); end
        n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_chk++; if (pc2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_pc2: got %h want ffffffff", pc2); end
        n_chk++; if ({wb_en, fault, use_imm, alu, fmt, rd, rs, imm} !== '0) begin
            n_fail++; $display("FAIL reset_outs: wb=%b flt=%b ui=%b alu=%h fmt=%h rd=%h rs=%h imm=%h want all 0",
                               wb_en, fault, use_imm, alu, fmt, rd, rs, imm);
        end
        repeat (3) @(posedge clk); #1;
        n_chk++; if (mif.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b want 0", mif.o_mem_req); end
    endtask

    task automatic test_basic();
        int cyc, reqs;
        do_reset();
        mem[0] = 8'h45; mem[1] = 8'h02;
        run = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (mif.o_mem_addr !== 32'd0 || mif.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_f0: addr=%h req=%b want 0/1", mif.o_mem_addr, mif.o_mem_req); end
        @(posedge clk); #1;
        n_chk++; if (mif.o_mem_addr !== 32'd1 || mif.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_f1: addr=%h req=%b want 1/1", mif.o_mem_addr, mif.o_mem_req); end
        @(posedge clk); #1;
        run = 1'b0;
        // 0x0245: action 5, fmt 0, rd = bits 9:6 = 4'b1001, rs 0, no imm
        n_chk++; if (wb_en !== 1'b1 || mif.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_exec: wb=%b req=%b want 1/0", wb_en, mif.o_mem_req); end
        n_chk++; if ({alu, fmt, rd, rs, use_imm} !== {4'd5, 2'd0, 4'd9, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL basic_decode: alu=%h fmt=%h rd=%h rs=%h ui=%b want 5/0/9/0/0", alu, fmt, rd, rs, use_imm);
        end
        n_chk++; if (pc !== 32'd2) begin n_fail++; $display("FAIL basic_pc: got %h want 2", pc); end
        @(posedge clk); #1;
        n_chk++; if (wb_en !== 1'b0 || mif.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_to_idle: wb=%b req=%b want 0/0", wb_en, mif.o_mem_req); end
        cyc = 0; reqs = 0;
        repeat (5) begin @(posedge clk); #1; if (mif.o_mem_req || wb_en) reqs++; end
        n_chk++; if (reqs !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", reqs); end
        n_chk++; if ({alu, rd} !== {4'd5, 4'd9}) begin n_fail++; $display("FAIL decode_stable: alu=%h rd=%h want 5/9", alu, rd); end
    endtask

    task automatic test_back_to_back();
        int cyc, reqs;
        do_reset();
        mem[0] = 8'h45; mem[1] = 8'h02; mem[2] = 8'h07; mem[3] = 8'h3C;
        run_instr(20, cyc, reqs);
        n_chk++; if (cyc !== 3 || reqs !== 2) begin n_fail++; $display("FAIL b2b_first: cycles=%0d reqs=%0d want 3/2", cyc, reqs); end
        run_instr(20, cyc, reqs);
        run = 1'b0;
        n_chk++; if (cyc !== 3 || reqs !== 2) begin n_fail++; $display("FAIL b2b_second: cycles=%0d reqs=%0d want 3/2", cyc, reqs); end
        n_chk++; if ({alu, fmt, rd, rs, use_imm, pc} !== {4'd7, 2'd0, 4'd0, 4'hF, 1'b0, 32'd4}) begin
            n_fail++; $display("FAIL b2b_decode: alu=%h fmt=%h rd=%h rs=%h ui=%b pc=%h want 7/0/0/f/0/4", alu, fmt, rd, rs, use_imm, pc);
        end
    endtask

    task automatic test_imm(input logic [1:0] f, input int nbytes, input logic [31:0] val);
        int cyc, reqs;
        do_reset();
        mem[0] = {2'b00, f, 4'h3}; mem[1] = 8'h40;
        for (int k = 0; k < nbytes; k++) mem[2 + k] = val[8*k +: 8];
        run_instr(30, cyc, reqs);
        run = 1'b0;
        n_chk++; if (cyc !== 3 + nbytes || reqs !== 2 + nbytes) begin
            n_fail++; $display("FAIL imm%0d_timing: cycles=%0d reqs=%0d want %0d/%0d", nbytes, cyc, reqs, 3 + nbytes, 2 + nbytes);
        end
        n_chk++; if (wb_en !== 1'b1 || imm !== val || use_imm !== 1'b1 || fmt !== f || alu !== 4'd3) begin
            n_fail++; $display("FAIL imm%0d_value: wb=%b imm=%h ui=%b fmt=%h alu=%h want 1/%h/1/%h/3", nbytes, wb_en, imm, use_imm, fmt, alu, val, f);
        end
        n_chk++; if (pc !== 32'(2 + nbytes)) begin n_fail++; $display("FAIL imm%0d_pc: got %h want %0d", nbytes, pc, 2 + nbytes); end
    endtask

    task automatic test_stall();
        int held = 0;
        do_reset();
        mem[0] = 8'h45; mem[1] = 8'h02;
        stall_addr = 32'd1; stall_cnt = 3;
        run = 1'b1;
        @(posedge clk); #1;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            if (mif.o_mem_req === 1'b1 && mif.o_mem_addr === 32'd1 && wb_en === 1'b0) held++;
        end
        n_chk++; if (held !== 4) begin n_fail++; $display("FAIL stall_hold: got %0d held cycles want 4", held); end
        @(posedge clk); #1;
        run = 1'b0;
        n_chk++; if (wb_en !== 1'b1 || pc !== 32'd2 || rd !== 4'd9) begin
            n_fail++; $display("FAIL stall_exec_cycle6: wb=%b pc=%h rd=%h want 1/2/9", wb_en, pc, rd);
        end
    endtask

    task automatic test_fault();
        int cyc, reqs, bad = 0;
        do_reset();
        mem[0] = 8'h41; mem[1] = 8'h80;
        run_instr(20, cyc, reqs);
        n_chk++; if (fault !== 1'b1 || wb_en !== 1'b0 || cyc !== 3) begin
            n_fail++; $display("FAIL fault_set: fault=%b wb=%b cycles=%0d want 1/0/3", fault, wb_en, cyc);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (mif.o_mem_req !== 1'b0 || wb_en !== 1'b0 || fault !== 1'b1) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL fault_sticky: got %0d bad cycles want 0", bad); end
        do_reset();
        n_chk++; if (fault !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL fault_clear: fault=%b pc=%h want 0/0", fault, pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (mif2.o_mem_addr !== 32'hFFFF_FFFF || mif2.o_mem_req !== 1'b1) begin
            n_fail++; $display("FAIL wrap_f0: addr=%h req=%b want ffffffff/1", mif2.o_mem_addr, mif2.o_mem_req);
        end
        @(posedge clk); #1;
        n_chk++; if (mif2.o_mem_addr !== 32'h0 || mif2.o_mem_req !== 1'b1) begin
            n_fail++; $display("FAIL wrap_f1: addr=%h req=%b want 0/1", mif2.o_mem_addr, mif2.o_mem_req);
        end
        @(posedge clk); #1;
        run = 1'b0;
        n_chk++; if (pc2 !== 32'd1 || wb_en2 !== 1'b1) begin n_fail++; $display("FAIL wrap_exec: pc=%h wb=%b want 1/1", pc2, wb_en2); end
    endtask

    task automatic test_reset_mid_imm();
        int c = 0;
        do_reset();
        mem[0] = {2'b00, FMT_4B, 4'h1}; mem[1] = 8'h40;
        mem[2] = 8'h78; mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
        stall_addr = 32'd3; stall_cnt = 100;
        run = 1'b1;
        while (!(mif.o_mem_req === 1'b1 && mif.o_mem_addr === 32'd3) && c < 20) begin @(posedge clk); #1; c++; end
        n_chk++; if (c >= 20 || imm !== 32'h78) begin n_fail++; $display("FAIL rstimm_reach: cycles=%0d imm=%h want <20/78", c, imm); end
        rst = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; force_ack = 1'b1;
        n_chk++; if ({mif.o_mem_req, wb_en, fault, use_imm, alu, fmt, rd, rs, imm} !== '0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL rstimm_reset: req=%b wb=%b imm=%h ui=%b pc=%h want all 0", mif.o_mem_req, wb_en, imm, use_imm, pc);
        end
        @(posedge clk); #1;
        force_ack = 1'b0; stall_cnt = 0;
        n_chk++; if ({mif.o_mem_req, wb_en, fault, use_imm, alu, fmt, rd, rs, imm} !== '0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL rstimm_late_ack: req=%b wb=%b imm=%h pc=%h alu=%h want all 0", mif.o_mem_req, wb_en, imm, pc, alu);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_imm(FMT_2B, 2, 32'h0000_1234);
        test_imm(FMT_4B, 4, 32'h1234_5678);
        test_imm(FMT_1B, 1, 32'h0000_00AB);
        test_stall();
        test_fault();
        test_wrap();
        test_reset_mid_imm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
